// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter state type for the interconnect blocks.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ST_PARK    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_LOCKED  = 2'd2
    } arb_state_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

endpackage

// File: rtl/ahb_rr_picker.sv
// Round-robin picker: first requester found cyclically after the owner, owner itself last.
module ahb_rr_picker #(
    parameter int N = 3,
    parameter int B = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [B-1:0] owner_i,
    output logic [B-1:0] next_o,
    output logic         valid_o
);

    function automatic logic [B-1:0] wrap_add(input logic [B-1:0] base, input int off);
        return B'((int'(base) + off) % N);
    endfunction

    // Scan from the farthest offset down so the nearest requester wins the last write.
    always_comb begin
        next_o = owner_i;
        for (int i = N; i >= 1; i--) begin
            if (req_i[wrap_add(owner_i, i)]) begin
                next_o = wrap_add(owner_i, i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/ahb_arbiter.sv
// AHB-Lite round-robin arbiter with lock support, hold-beat cap and address/data owner tracking.
//   state      | meaning
//   ST_PARK    | no requester; grant parked on PARK_MANAGER
//   ST_GRANTED | owner holds grant; may rotate at a burst boundary
//   ST_LOCKED  | owner in a locked sequence; no rotation until HLOCK drops at a boundary
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NO_OF_MANAGERS    = 3,
    parameter int BITS_FOR_MANAGERS = 2,
    parameter int PARK_MANAGER      = 0,
    parameter int MAX_HOLD_BEATS    = 16
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    input  logic [NO_OF_MANAGERS-1:0]    HBUSREQ,
    input  logic [NO_OF_MANAGERS-1:0]    HLOCK,
    input  logic [1:0]                   HTRANS,
    input  logic                         HREADY,
    output logic [NO_OF_MANAGERS-1:0]    HGRANT,
    output logic [BITS_FOR_MANAGERS-1:0] HMASTER,
    output logic [BITS_FOR_MANAGERS-1:0] HMASTER_D,
    output logic                         HMASTLOCK
);

    localparam int CW = $clog2(MAX_HOLD_BEATS + 1);
    localparam logic [CW-1:0]                CNT_MAX  = CW'(MAX_HOLD_BEATS);
    localparam logic [BITS_FOR_MANAGERS-1:0] PARK_IDX = BITS_FOR_MANAGERS'(PARK_MANAGER);
    localparam logic [NO_OF_MANAGERS-1:0]    ONE      = NO_OF_MANAGERS'(1);

    arb_state_e                   state_q, state_d, eval_state;
    logic [BITS_FOR_MANAGERS-1:0] idx_q, idx_d, eval_idx, pick_idx;
    logic [NO_OF_MANAGERS-1:0]    hgrant_q;
    logic [BITS_FOR_MANAGERS-1:0] hmaster_q, hmaster_d_q;
    logic                         hmastlock_q;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic                         pick_valid, boundary, cnt_sat, other_req;

    ahb_rr_picker #(
        .N(NO_OF_MANAGERS),
        .B(BITS_FOR_MANAGERS)
    ) u_picker (
        .req_i  (HBUSREQ),
        .owner_i(idx_q),
        .next_o (pick_idx),
        .valid_o(pick_valid)
    );

    assign boundary  = (HTRANS == HTRANS_IDLE) || (HTRANS == HTRANS_NONSEQ);
    assign cnt_sat   = (cnt_q == CNT_MAX);
    assign other_req = |(HBUSREQ & ~hgrant_q);

    // Rotation decision shared by GRANTED and by the LOCKED exit cycle.
    always_comb begin
        eval_state = ST_GRANTED;
        eval_idx   = idx_q;
        if (!pick_valid) begin
            eval_state = ST_PARK;
            eval_idx   = PARK_IDX;
        end else if (!HBUSREQ[idx_q] || (cnt_sat && other_req)) begin
            eval_idx = pick_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_PARK: begin
                if (pick_valid) begin
                    state_d = ST_GRANTED;
                    if (boundary) idx_d = pick_idx;
                end
            end
            ST_GRANTED: begin
                if (boundary) begin
                    if (HLOCK[idx_q]) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = eval_state;
                        idx_d   = eval_idx;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary && !HLOCK[idx_q]) begin
                    state_d = eval_state;
                    idx_d   = eval_idx;
                end
            end
            default: begin
                state_d = ST_PARK;
                idx_d   = PARK_IDX;
            end
        endcase
    end

    always_comb begin
        if (idx_d != idx_q)           cnt_d = '0;
        else if (HTRANS[1] && !cnt_sat) cnt_d = cnt_q + CW'(1);
        else                          cnt_d = cnt_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_PARK;
            idx_q       <= PARK_IDX;
            hgrant_q    <= ONE << PARK_IDX;
            hmaster_q   <= PARK_IDX;
            hmaster_d_q <= PARK_IDX;
            hmastlock_q <= 1'b0;
            cnt_q       <= '0;
        end else if (HREADY) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hgrant_q    <= ONE << idx_d;
            hmaster_q   <= idx_q;
            hmaster_d_q <= hmaster_q;
            hmastlock_q <= HLOCK[idx_q];
            cnt_q       <= cnt_d;
        end
    end

    assign HGRANT    = hgrant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTER_D = hmaster_d_q;
    assign HMASTLOCK = hmastlock_q;

endmodule
